// File: rtl/alu_arb_ctrl.sv
// alu_arb_ctrl: two-requester round-robin arbiter and sequencer for a shared
// 16-bit ALU. It accepts one op at a time and holds the registered ALU inputs
// for the op's latency. It then captures the result and flags and returns
// them on a response handshake tagged with the requester id.
// Optional feature macro: ALU_ARB_CARRY_CHAIN_EN adds a stored carry per
// requester. That carry replaces the carry-in bit of add/sub/shift ops that
// ask for one, so multi-word chains can be built.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is only raised in IDLE. rsp_valid stays high, with
// rsp_* stable, until the cycle in which rsp_ready is seen.
`timescale 1ns/1ps

module alu_arb_ctrl #(
   parameter int unsigned MUL_CYCLES    = 2,
   parameter int unsigned NONMUL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic [4:0]  req0_op,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   input  logic [4:0]  req1_op,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [4:0]  alu_op,
   output logic        alu_ci,
   input  logic [15:0] alu_y,
   input  logic        alu_carry,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [15:0] rsp_y,
   output logic        rsp_zero,
   output logic        rsp_neg,
   output logic        rsp_carry,
   output logic        rsp_err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic        r_rr_last;
   logic [3:0]  r_cnt;
   logic [15:0] r_alu_a;
   logic [15:0] r_alu_b;
   logic [4:0]  r_alu_op;
   logic        r_rsp_id;
   logic [15:0] r_rsp_y;
   logic        r_rsp_zero;
   logic        r_rsp_neg;
   logic        r_rsp_carry;
   logic        r_rsp_err;

   logic        w_grant;
   logic        w_grant_vld;
   logic [15:0] w_sel_a;
   logic [15:0] w_sel_b;
   logic [4:0]  w_sel_op;
   logic [4:0]  w_lat_op;
   logic        w_sel_err;
   logic        w_sel_mul;
   logic        w_rsp_hs;

   // Round-robin grant: the requester that did not win last time has priority.
   always_comb begin
      w_grant     = 1'b0;
      w_grant_vld = 1'b0;
      if (req_valid[~r_rr_last]) begin
         w_grant     = ~r_rr_last;
         w_grant_vld = 1'b1;
      end else if (req_valid[r_rr_last]) begin
         w_grant     = r_rr_last;
         w_grant_vld = 1'b1;
      end
   end

   assign w_sel_a   = w_grant ? req1_a  : req0_a;
   assign w_sel_b   = w_grant ? req1_b  : req0_b;
   assign w_sel_op  = w_grant ? req1_op : req0_op;
   assign w_sel_err = (w_sel_op[3:0] == 4'd14) || (w_sel_op[3:0] == 4'd15);
   assign w_sel_mul = (w_sel_op[3:0] == 4'd13);
   assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready;

`ifdef ALU_ARB_CARRY_CHAIN_EN
   logic [1:0] r_carry;

   // Carry-in requests on add/sub/shift ops use the requester's stored carry.
   always_comb begin
      w_lat_op = w_sel_op;
      if (w_sel_op[4] && ((w_sel_op[3:0] == 4'd1) || (w_sel_op[3:0] == 4'd2) ||
                          (w_sel_op[3:0] == 4'd8) || (w_sel_op[3:0] == 4'd9))) begin
         w_lat_op[4] = r_carry[w_grant];
      end
   end

   // Remember each requester's carry when its non-error response is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_carry <= 2'b00;
      end else if (w_rsp_hs && !r_rsp_err) begin
         r_carry[r_rsp_id] <= r_rsp_carry;
      end
   end
`else
   assign w_lat_op = w_sel_op;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and the one-cycle accept strobe.
   always_comb begin
      w_next_state = r_state;
      req_ready    = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (w_grant_vld) begin
               req_ready    = w_grant ? 2'b10 : 2'b01;
               w_next_state = w_sel_err ? S_RESP : S_EXEC;
            end
         end
         S_EXEC: begin
            if (r_cnt == 4'd1) begin
               w_next_state = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Operand latch, hold counter and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_last   <= 1'b1;
         r_cnt       <= 4'd0;
         r_alu_a     <= 16'h0000;
         r_alu_b     <= 16'h0000;
         r_alu_op    <= 5'd0;
         r_rsp_id    <= 1'b0;
         r_rsp_y     <= 16'h0000;
         r_rsp_zero  <= 1'b0;
         r_rsp_neg   <= 1'b0;
         r_rsp_carry <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_vld) begin
                  r_rsp_id  <= w_grant;
                  r_rr_last <= w_grant;
                  if (w_sel_err) begin
                     // Illegal opcode: answer at once, ALU inputs untouched.
                     r_rsp_y     <= 16'h0000;
                     r_rsp_zero  <= 1'b1;
                     r_rsp_neg   <= 1'b0;
                     r_rsp_carry <= 1'b0;
                     r_rsp_err   <= 1'b1;
                  end else begin
                     r_alu_a  <= w_sel_a;
                     r_alu_b  <= w_sel_b;
                     r_alu_op <= w_lat_op;
                     r_cnt    <= w_sel_mul ? 4'(MUL_CYCLES) : 4'(NONMUL_CYCLES);
                  end
               end
            end
            S_EXEC: begin
               if (r_cnt == 4'd1) begin
                  // Flags are derived here from the result, not from the ALU.
                  r_rsp_y     <= alu_y;
                  r_rsp_zero  <= (alu_y == 16'h0000);
                  r_rsp_neg   <= alu_y[15];
                  r_rsp_carry <= alu_carry;
                  r_rsp_err   <= 1'b0;
               end
               r_cnt <= r_cnt - 4'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_op    = r_alu_op;
   assign alu_ci    = r_alu_op[4];
   assign rsp_valid = (r_state == S_RESP);
   assign rsp_id    = r_rsp_id;
   assign rsp_y     = r_rsp_y;
   assign rsp_zero  = r_rsp_zero;
   assign rsp_neg   = r_rsp_neg;
   assign rsp_carry = r_rsp_carry;
   assign rsp_err   = r_rsp_err;
   assign dbg_state = r_state;

endmodule

// File: doc/alu_arb_ctrl.md
Name: alu_arb_ctrl

Overview:
Two-requester round-robin arbiter and sequencer in front of the shared 16-bit ALU. It accepts one operation at a time from either requester, drives the ALU operands and opcode from registers, and holds them for the op's latency (multi-cycle for multiply). It then captures the result and flags and returns them on a response handshake tagged with the requester ID.

Parameters:
MUL_CYCLES, 2, cycles the ALU inputs are held for opcode 13 (multiply); legal range 1..15
NONMUL_CYCLES, 1, cycles held for all other legal opcodes; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  bit n = requester n has an op pending
req_ready  out  2  bit n = op from requester n accepted this cycle
req0_a  in  16  requester 0 operand A
req0_b  in  16  requester 0 operand B
req0_op  in  5  requester 0 opcode; [3:0] ALU op, [4] carry-in/shift-in bit
req1_a  in  16  requester 1 operand A
req1_b  in  16  requester 1 operand B
req1_op  in  5  requester 1 opcode
alu_a  out  16  ALU operand A, registered
alu_b  out  16  ALU operand B, registered
alu_op  out  5  ALU opcode, registered
alu_ci  out  1  ALU carry input; always equals alu_op[4]
alu_y  in  16  ALU result
alu_carry  in  1  ALU carry output
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the op
rsp_y  out  16  captured result
rsp_zero  out  1  rsp_y == 0
rsp_neg  out  1  rsp_y[15]
rsp_carry  out  1  captured alu_carry
rsp_err  out  1  opcode [3:0] was 14 or 15

Behaviour:
- Reset, async, rst_n low:
  - state IDLE; all outputs 0.
  - rr_last = 1, so requester 0 wins the first contention.
  - Reset mid-operation aborts the op and drops any pending response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g: the requester not equal to rr_last if its valid is set, otherwise the other one if valid.
  - req_ready[g] = 1 combinationally for that cycle only; it is never asserted outside IDLE.
  - On the edge:
    - latch req_g_a, req_g_b and op into alu_a, alu_b and alu_op.
    - rsp_id <= g; rr_last <= g.
    - cnt <= MUL_CYCLES if op[3:0] == 13, else NONMUL_CYCLES.
    - Go to EXEC.
  - If op[3:0] is 14 or 15, skip EXEC and go directly to RESP with:
    - rsp_y = 0, rsp_zero = 1, rsp_neg = 0, rsp_carry = 0, rsp_err = 1.
    - alu_* unchanged.
- EXEC:
  - alu_* held stable; cnt decrements each cycle.
  - When cnt == 1, on that edge:
    - rsp_y <= alu_y; rsp_zero <= (alu_y == 0); rsp_neg <= alu_y[15]; rsp_carry <= alu_carry; rsp_err <= 0.
    - Go to RESP.
  - Latency from the accept edge to rsp_valid high = cnt cycles, i.e. 1 for NONMUL_CYCLES = 1.
- RESP:
  - rsp_valid = 1; rsp_* held stable until accepted.
  - On rsp_valid & rsp_ready, go to IDLE; rsp_valid drops next cycle.
  - New requests wait; no accept in the same cycle as the response handshake.
- Zero and Neg are computed here from alu_y, never taken from the ALU.
- Throughput: one op per NONMUL_CYCLES + 2 cycles minimum.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- A requester may drop or change req_valid or operands while not granted; there is no requirement to hold them.

Optional Feature:
Macro ALU_ARB_CARRY_CHAIN_EN.
- Defined:
  - One carry register per requester, reset 0, updated with rsp_carry when that requester's non-error response is accepted.
  - For op[3:0] in {1,2,8,9} with op[4] = 1, the latched alu_op[4] (and so alu_ci) is the requester's stored carry instead of literal 1. This enables multi-word add/sub/shift chains.
  - For op[4] = 0, and for all other opcodes, alu_op[4] is latched verbatim.
- Undefined: alu_op is latched verbatim; no carry registers exist.

Test Plan:
- Reset, then req_valid = 01, req0 = (A=0x0003, B=0x0004, op=1), rsp_ready = 1 -> req_ready = 01 for 1 cycle; rsp_valid 1 cycle later with rsp_y = 0x0007, zero = 0, neg = 0, id = 0.
- req_valid = 11 held, both op = 0 (B passthrough), B0 = 0x1111, B1 = 0x2222 -> responses in order id 0,1,0,1 with rsp_y 0x1111,0x2222,...
- req1 op = 13, A = 0x0010, B = 0x0010, MUL_CYCLES = 3 -> alu_* stable for 3 cycles; rsp_y = 0x0100, rsp_id = 1.
- req0 op = 2, A = 0x0005, B = 0x0005 -> rsp_y = 0x0000, rsp_zero = 1; then op = 7, A = 0x0001 -> rsp_y = 0xFFFF, rsp_neg = 1.
- req0 op = 14 -> no EXEC; rsp_err = 1, rsp_y = 0, rsp_zero = 1. Then hold rsp_ready = 0 for 5 cycles -> rsp_* stable and req_ready stays 00.
- rst_n pulsed low during EXEC of a multiply -> rsp_valid = 0 and alu_* = 0 immediately. Next req_valid = 11 grants requester 0. With ALU_ARB_CARRY_CHAIN_EN: req0 op = 1, A = 0xFFFF, B = 0x0001, with the ALU returning carry = 1, then req0 op = 0x11 -> alu_ci = 1.
